// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider slice.
//   div_state_t        : controller states (IDLE, CALC, DONE)
//   DIV_WIDTH_DEFAULT  : default operand/result width
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH_DEFAULT = 8;

endpackage : div_pkg

// File: rtl/restoring_divider_8bit_sub_ripple.sv
// sub_ripple: (WIDTH+1)-bit ripple subtractor, diff = a - b.
// It is built as a ripple-carry adder computing a + ~b + 1 from full-adder
// cells. The carry out of the top cell is high when no borrow occurred.
// Ports:
//   a, b    in   WIDTH+1  minuend, subtrahend
//   diff    out  WIDTH+1  a - b (modulo 2^(WIDTH+1))
//   borrow  out  1        1 when a < b (unsigned)
module sub_ripple
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  output logic [WIDTH:0] diff,
  output logic           borrow
);

  logic [WIDTH+1:0] carry;
  logic [WIDTH:0]   b_n;

  assign carry[0] = 1'b1;
  assign b_n      = ~b;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
    assign diff[i]    = a[i] ^ b_n[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b_n[i]) | (carry[i] & (a[i] ^ b_n[i]));
  end

  assign borrow = ~carry[WIDTH+1];

endmodule : sub_ripple

// File: rtl/restoring_divider_8bit.sv
// restoring_divider_8bit: multi-cycle restoring divider with a start/valid
// handshake. It computes one quotient bit per clock, MSB first, and uses a
// single ripple subtract stage on every step.
// Ports:
//   clk          in   1      rising-edge clock
//   rst_n        in   1      synchronous, active-low reset
//   start        in   1      request, accepted only while ready=1
//   dividend     in   WIDTH  sampled on accept
//   divisor      in   WIDTH  sampled on accept
//   ready        out  1      high in IDLE/DONE
//   valid        out  1      one-cycle pulse when new results are present
//   quotient     out  WIDTH  held until the next result
//   remainder    out  WIDTH  held until the next result
//   div_by_zero  out  1      set with valid when divisor was 0
// Build option: define DIV_SIGNED_EN for two's-complement (truncating)
// division. When it is undefined, the datapath is purely unsigned.
module restoring_divider_8bit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t       state, state_next;
  logic [CNT_W-1:0] count;
  // After every step the partial remainder is smaller than the divisor.
  // For that reason only its low WIDTH bits are kept between steps.
  logic [WIDTH-1:0] part_r;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] work_d;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH-1:0] q_step, r_step;
  logic [WIDTH-1:0] q_final, r_final;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             accept, zero_div, last_step;
  logic             unused_diff_msb;

`ifdef DIV_SIGNED_EN
  logic             neg_q, neg_r;
`endif

  assign accept    = start && ready;
  assign zero_div  = (divisor == '0);
  assign last_step = (state == CALC) && (count == CNT_W'(WIDTH - 1));

  // One restoring step: shift the next dividend bit into R, then trial-subtract D.
  assign r_shift = {part_r, work_q[WIDTH-1]};

  sub_ripple #(.WIDTH(WIDTH)) u_sub (
    .a      (r_shift),
    .b      ({1'b0, work_d}),
    .diff   (diff),
    .borrow (borrow)
  );

  assign q_step          = {work_q[WIDTH-2:0], ~borrow};
  assign r_step          = borrow ? r_shift[WIDTH-1:0] : diff[WIDTH-1:0];
  assign unused_diff_msb = diff[WIDTH];

  // Operand magnitudes and sign correction of the result.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so that no path can infer a latch.
    a_mag   = dividend;
    b_mag   = divisor;
    q_final = q_step;
    r_final = r_step;
`ifdef DIV_SIGNED_EN
    if (dividend[WIDTH-1]) a_mag = -dividend;
    if (divisor[WIDTH-1])  b_mag = -divisor;
    // MIN/-1: the magnitude quotient 2^(WIDTH-1) is not negated and reads back as MIN.
    if (neg_q) q_final = -q_step;
    if (neg_r) r_final = -r_step;
`endif
  end

  // Next-state logic. DONE accepts a start exactly like IDLE does.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE: if (start) state_next = zero_div ? DONE : CALC;
      CALC:       if (last_step) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    ready = (state != CALC);
  end

  // All state: the controller, the working registers and the result registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      part_r      <= '0;
      work_q      <= '0;
      work_d      <= '0;
      valid       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      state <= state_next;
      valid <= 1'b0;
      if (accept) begin
        count  <= '0;
        part_r <= '0;
        work_q <= a_mag;
        work_d <= b_mag;
`ifdef DIV_SIGNED_EN
        neg_q  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
        neg_r  <= dividend[WIDTH-1];
`endif
        if (zero_div) begin
          quotient    <= '1;
          remainder   <= dividend;
          div_by_zero <= 1'b1;
          valid       <= 1'b1;
        end else begin
          div_by_zero <= 1'b0;
        end
      end else if (state == CALC) begin
        count  <= count + CNT_W'(1);
        part_r <= r_step;
        work_q <= q_step;
        if (last_step) begin
          quotient  <= q_final;
          remainder <= r_final;
          valid     <= 1'b1;
        end
      end
    end
  end

endmodule : restoring_divider_8bit

// File: tb/tb_restoring_divider_8bit.sv
// Self-checking bench for restoring_divider_8bit (WIDTH=8).
// The driver predicts acceptance and result timing. It also computes the
// results with plain integer division and queues them. An independent
// monitor compares each valid pulse against the queue.
// The model follows DIV_SIGNED_EN in the same way as the design.
`timescale 1ns/1ps
module tb_restoring_divider_8bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend, divisor;
  logic       ready, valid, div_by_zero;
  logic [7:0] quotient, remainder;

  restoring_divider_8bit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .valid       (valid),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   free_at = 0;
  logic ready_exp = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference behaviour taken from the arithmetic definition.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input int due);
    exp_t e;
    e.due = due;
    if (b == 8'd0) begin
      e.q = 8'hFF; e.r = a; e.dbz = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      int sa, sd, qi, ri;
      sa = int'($signed(a));
      sd = int'($signed(b));
      qi = sa / sd;
      ri = sa % sd;
      e.q = qi[7:0]; e.r = ri[7:0];
`else
      e.q = a / b; e.r = a % b;
`endif
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Drive one cycle of stimulus. If the model accepts the request, push the expected result.
  task automatic step(input logic s, input logic [7:0] a, input logic [7:0] b);
    start     = s;
    dividend  = a;
    divisor   = b;
    ready_exp = (cyc >= free_at);
    if (s && rst_n && ready_exp) begin
      exp_t e;
      e = model(a, b, cyc + ((b == 8'd0) ? 1 : 9));
      sb.push_back(e);
      free_at = e.due;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'd0, 8'd0);
  endtask

  task automatic check_reset_state();
    check("rst_ready", ready, 1'b1);
    check("rst_valid", valid, 1'b0);
    check("rst_quotient", quotient, 8'd0);
    check("rst_remainder", remainder, 8'd0);
    check("rst_dbz", div_by_zero, 1'b0);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("ready", ready, ready_exp);
        while (sb.size() > 0 && sb[0].due < cyc) begin
          errors++; checks++;
          $display("FAIL missing_valid: no valid seen, expected at cycle %0d (now %0d)", sb[0].due, cyc);
          void'(sb.pop_front());
        end
        if (valid) begin
          if (sb.size() == 0) begin
            errors++; checks++;
            $display("FAIL unexpected_valid @cycle %0d: q=0x%0h r=0x%0h, expected no valid", cyc, quotient, remainder);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("valid_cycle", cyc, e.due);
            check("quotient", quotient, e.q);
            check("remainder", remainder, e.r);
            check("div_by_zero", div_by_zero, e.dbz);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] a, b;
    rst_n = 1'b0;
    start = 1'b0; dividend = '0; divisor = '0;
    idle(2);
    check_reset_state();
    rst_n = 1'b1;
    free_at = 0;

    // Directed vectors.
    step(1'b1, 8'd200, 8'd7); idle(10);
    step(1'b1, 8'd5, 8'd0);   idle(2);
    step(1'b1, 8'd9, 8'd3);   idle(10);
    step(1'b1, 8'd0, 8'd3);   idle(10);
    step(1'b1, 8'd255, 8'd1); idle(10);
    step(1'b1, 8'd3, 8'd200); idle(10);
`ifdef DIV_SIGNED_EN
    step(1'b1, 8'h9C, 8'd7);  idle(10);  // -100 / 7
    step(1'b1, 8'd100, 8'hF9); idle(10); // 100 / -7
    step(1'b1, 8'h80, 8'hFF); idle(10);  // -128 / -1
`endif

    // A start during CALC is ignored.
    step(1'b1, 8'd100, 8'd9);
    idle(1);
    for (int i = 0; i < 7; i++) step(1'b1, 8'd1, 8'd1);
    idle(4);

    // Hold start high back-to-back: a new request is accepted in each valid cycle.
    for (int i = 0; i < 30; i++) begin
      b = 8'($urandom_range(1, 255));
      step(1'b1, 8'($urandom), b);
    end
    idle(10);

    // Reset in the fourth CALC cycle aborts the division.
    step(1'b1, 8'd200, 8'd7);
    idle(3);
    rst_n = 1'b0;
    sb.delete();
    free_at = 0;
    step(1'b0, 8'd0, 8'd0);
    check_reset_state();
    rst_n = 1'b1;
    idle(12);

    // Random traffic with gaps, zero divisors and starts issued while busy.
    for (int i = 0; i < 300; i++) begin
      a = 8'($urandom);
      case ($urandom_range(0, 9))
        0:       b = 8'd0;
        1, 2:    b = 8'($urandom_range(1, 4));
        default: b = 8'($urandom);
      endcase
      step($urandom_range(0, 3) != 0, a, b);
    end

    // Bounded drain.
    for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1);
    idle(2);
    check("drain", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_restoring_divider_8bit
